// File: rtl/ppm_pkg.sv
// rtl/ppm_pkg.sv - shared PPM types, limits and transmit FSM state encoding
package ppm_pkg;

    typedef logic [7:0] ppm_chan_t;

    localparam int PPM_MAX_CHANNELS = 8;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        GAP,
        TERM,
        SYNC
    } ppm_tx_state_t;

endpackage

// File: rtl/ppm_tick_gen.sv
// rtl/ppm_tick_gen.sv - free-running prescaler producing a one-cycle tick_en every CLKS_PER_TICK clocks
//   clk      in  clock
//   reset    in  synchronous, active-high
//   tick_en  out high on the wrap cycle of the prescaler
module ppm_tick_gen #(
    parameter int CLKS_PER_TICK = 200
) (
    input  logic clk,
    input  logic reset,
    output logic tick_en
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick_en = (count == LAST);

endmodule

// File: rtl/ppm_tx_encoder.sv
// rtl/ppm_tx_encoder.sv - RC PPM pulse-train transmitter with per-frame channel snapshot
//   clk          in  clock
//   reset        in  synchronous, active-high
//   enable       in  1 = continuous frames, 0 = stop after the current frame
//   channels     in  NUM_CHANNELS x 8-bit channel values
//   ppm_out      out PPM line, idle low, pulses high
//   frame_start  out one-cycle strobe on the first cycle of each frame
//   busy         out high while a frame (PULSE/GAP/TERM/SYNC) is in progress
//   slot_index   out slot being transmitted; terminal pulse and sync report NUM_CHANNELS-1
module ppm_tx_encoder
    import ppm_pkg::*;
#(
    parameter int NUM_CHANNELS   = 8,
    parameter int CLKS_PER_TICK  = 200,
    parameter int PULSE_TICKS    = 75,
    parameter int BASE_TICKS     = 250,
    parameter int FRAME_TICKS    = 5625,
    parameter int MIN_SYNC_TICKS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] channels [0:NUM_CHANNELS-1],
    output logic       ppm_out,
    output logic       frame_start,
    output logic       busy,
    output logic [2:0] slot_index
);

    localparam logic [2:0]  LAST_SLOT  = 3'(NUM_CHANNELS - 1);
    localparam logic [15:0] PULSE_LOAD = 16'(PULSE_TICKS - 1);
    localparam logic [15:0] FRAME_T    = 16'(FRAME_TICKS);
    localparam logic [15:0] MIN_SYNC   = 16'(MIN_SYNC_TICKS);

    ppm_tx_state_t state;
    logic [15:0]   cnt;
    logic [15:0]   frame_ticks;
    ppm_chan_t     shadow [0:NUM_CHANNELS-1];
    logic          tick_en;

    ppm_tick_gen #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .tick_en(tick_en)
    );

    // Value of the slot currently on air; a mux keeps the 3-bit index in range
    // when fewer than eight channels are configured.
    ppm_chan_t cur_val;
    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (slot_index == 3'(i)) cur_val = shadow[i];
        end
    end

    // Gap after the pulse so that leading edges are BASE_TICKS+value apart.
    logic [15:0] gap_load;
    assign gap_load = 16'(BASE_TICKS) + {8'd0, cur_val} - 16'(PULSE_TICKS) - 16'd1;

    // frame_ticks excludes the tick that ends TERM, hence the +1. The clamp
    // compares before subtracting so the 16-bit difference can never wrap.
    logic [15:0] elapsed;
    logic [15:0] sync_len;
    always_comb begin
        elapsed  = frame_ticks + 16'd1;
        sync_len = MIN_SYNC;
        if (elapsed < FRAME_T && (FRAME_T - elapsed) > MIN_SYNC) begin
            sync_len = FRAME_T - elapsed;
        end
    end

    // A new frame begins from IDLE or directly at the end of SYNC, so back-to-back
    // frames have no idle tick between them.
    logic start_now;
    assign start_now = tick_en && enable &&
                       ((state == IDLE) || (state == SYNC && cnt == 16'd0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            frame_ticks <= '0;
            ppm_out     <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            slot_index  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) shadow[i] <= '0;
        end else begin
            frame_start <= 1'b0;
            if (tick_en && state != IDLE) frame_ticks <= frame_ticks + 16'd1;

            if (start_now) begin
                for (int i = 0; i < NUM_CHANNELS; i++) shadow[i] <= channels[i];
                slot_index  <= '0;
                frame_ticks <= '0;
                frame_start <= 1'b1;
                state       <= PULSE;
                ppm_out     <= 1'b1;
                busy        <= 1'b1;
                cnt         <= PULSE_LOAD;
            end else if (tick_en && state != IDLE) begin
                if (cnt != 16'd0) begin
                    cnt <= cnt - 16'd1;
                end else begin
                    case (state)
                        PULSE: begin
                            state   <= GAP;
                            ppm_out <= 1'b0;
                            cnt     <= gap_load;
                        end
                        GAP: begin
                            if (slot_index < LAST_SLOT) begin
                                slot_index <= slot_index + 3'd1;
                                state      <= PULSE;
                            end else begin
                                state <= TERM;
                            end
                            ppm_out <= 1'b1;
                            cnt     <= PULSE_LOAD;
                        end
                        TERM: begin
                            state   <= SYNC;
                            ppm_out <= 1'b0;
                            cnt     <= sync_len - 16'd1;
                        end
                        SYNC: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                        default: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ppm_tx_encoder.sv
// tb/tb_ppm_tx_encoder.sv - directed self-checking bench for ppm_tx_encoder (scaled-down timing)
module tb_ppm_tx_encoder;

    // 1 tick = 2 clk; pulse 3 ticks = 6 clk; slot = (10+v) ticks = 2*(10+v) clk;
    // frame 200 ticks = 400 clk unless sync clamps to 20 ticks.
    localparam int NCH   = 8;
    localparam int CPT   = 2;
    localparam int PULSE = 3;
    localparam int BASE  = 10;
    localparam int FRAME = 200;
    localparam int MINS  = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] channels [0:NCH-1];
    logic       ppm_out;
    logic       frame_start;
    logic       busy;
    logic [2:0] slot_index;

    ppm_tx_encoder #(
        .NUM_CHANNELS  (NCH),
        .CLKS_PER_TICK (CPT),
        .PULSE_TICKS   (PULSE),
        .BASE_TICKS    (BASE),
        .FRAME_TICKS   (FRAME),
        .MIN_SYNC_TICKS(MINS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .channels   (channels),
        .ppm_out    (ppm_out),
        .frame_start(frame_start),
        .busy       (busy),
        .slot_index (slot_index)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    int rise_t [0:15];
    int fall_t [0:15];
    int rise_slot [0:15];
    int n_rise, n_fall, period;
    bit got_next, start_pending, start_ppm;

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < NCH; i++) channels[i] = v;
    endtask

    // Record one frame from its frame_start until the next frame_start or busy low.
    // action 1: channels := 20 once rise action_rise is seen; action 2: enable := 0.
    task automatic capture(input int action, input int action_rise, output bit ok);
        int t0;
        int w;
        bit prev;
        bit done_action;
        ok = 1; got_next = 0; n_rise = 0; n_fall = 0; period = 0; done_action = 0;
        if (!start_pending) begin
            w = 0;
            while (frame_start !== 1'b1 && w < 6000) begin
                @(negedge clk);
                w++;
            end
            if (frame_start !== 1'b1) begin
                ok = 0;
                return;
            end
        end
        start_pending = 0;
        t0 = cyc;
        start_ppm = ppm_out;
        rise_t[0] = 0;
        rise_slot[0] = int'(slot_index);
        n_rise = 1;
        prev = ppm_out;
        while (1) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                got_next = 1;
                period = cyc - t0;
                break;
            end
            if (ppm_out && !prev) begin
                if (n_rise < 16) begin
                    rise_t[n_rise] = cyc - t0;
                    rise_slot[n_rise] = int'(slot_index);
                end
                n_rise++;
            end
            if (!ppm_out && prev) begin
                if (n_fall < 16) fall_t[n_fall] = cyc - t0;
                n_fall++;
            end
            prev = ppm_out;
            if (!done_action && n_rise == action_rise) begin
                if (action == 1) set_all(8'd20);
                if (action == 2) enable = 1'b0;
                done_action = 1;
            end
            if (busy !== 1'b1) begin
                period = cyc - t0;
                break;
            end
            if (cyc - t0 > 6000) begin
                ok = 0;
                break;
            end
        end
        start_pending = got_next;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b0;
        set_all(8'd0);
        repeat (3) @(negedge clk);
        n_cmp++; if (ppm_out !== 1'b0) begin n_fail++; $display("FAIL reset_ppm_out got %b want 0", ppm_out); end
        n_cmp++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (slot_index !== 3'd0) begin n_fail++; $display("FAIL reset_slot_index got %0d want 0", slot_index); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy_without_enable got %b want 0", busy); end
    endtask

    task automatic test_zero_frame;
        bit ok;
        set_all(8'd0);
        enable = 1'b1;
        start_pending = 0;
        capture(0, 0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL zero_capture timed out"); end
        n_cmp++; if (start_ppm !== 1'b1) begin n_fail++; $display("FAIL zero_ppm_at_start got %b want 1", start_ppm); end
        n_cmp++; if (n_rise != 9) begin n_fail++; $display("FAIL zero_rise_count got %0d want 9", n_rise); end
        for (int k = 1; k < 9; k++) begin
            n_cmp++;
            if (rise_t[k] - rise_t[k-1] != 20) begin
                n_fail++; $display("FAIL zero_spacing[%0d] got %0d want 20", k, rise_t[k] - rise_t[k-1]);
            end
        end
        n_cmp++; if (fall_t[0] - rise_t[0] != 6) begin n_fail++; $display("FAIL zero_pulse_width got %0d want 6", fall_t[0] - rise_t[0]); end
        n_cmp++; if (fall_t[8] - rise_t[8] != 6) begin n_fail++; $display("FAIL zero_term_width got %0d want 6", fall_t[8] - rise_t[8]); end
        n_cmp++; if (!got_next || period != 400) begin n_fail++; $display("FAIL zero_period got %0d want 400", period); end
        for (int k = 0; k < 9; k++) begin
            n_cmp++;
            if (rise_slot[k] != ((k < 8) ? k : 7)) begin
                n_fail++; $display("FAIL zero_slot_index[%0d] got %0d want %0d", k, rise_slot[k], (k < 8) ? k : 7);
            end
        end
    endtask

    task automatic test_mixed_values;
        bit ok;
        set_all(8'd6);
        channels[3] = 8'd40;
        capture(0, 0, ok);
        capture(0, 0, ok);
        n_cmp++; if (!ok || n_rise != 9) begin n_fail++; $display("FAIL mixed_rise_count got %0d want 9", n_rise); end
        for (int k = 1; k < 9; k++) begin
            n_cmp++;
            if (rise_t[k] - rise_t[k-1] != ((k == 4) ? 100 : 32)) begin
                n_fail++; $display("FAIL mixed_spacing[%0d] got %0d want %0d", k, rise_t[k] - rise_t[k-1], (k == 4) ? 100 : 32);
            end
        end
        n_cmp++; if (!got_next || period != 400) begin n_fail++; $display("FAIL mixed_period got %0d want 400", period); end
    endtask

    task automatic test_snapshot;
        bit ok;
        set_all(8'd6);
        capture(0, 0, ok);
        capture(1, 3, ok);
        n_cmp++; if (!ok || n_rise != 9) begin n_fail++; $display("FAIL snap_rise_count got %0d want 9", n_rise); end
        for (int k = 1; k < 9; k++) begin
            n_cmp++;
            if (rise_t[k] - rise_t[k-1] != 32) begin
                n_fail++; $display("FAIL snap_old_spacing[%0d] got %0d want 32", k, rise_t[k] - rise_t[k-1]);
            end
        end
        capture(0, 0, ok);
        for (int k = 1; k < 9; k++) begin
            n_cmp++;
            if (rise_t[k] - rise_t[k-1] != 60) begin
                n_fail++; $display("FAIL snap_new_spacing[%0d] got %0d want 60", k, rise_t[k] - rise_t[k-1]);
            end
        end
        // 8*30+3 = 243 ticks exceeds the frame, so sync clamps to 20: 263 ticks.
        n_cmp++; if (!got_next || period != 526) begin n_fail++; $display("FAIL snap_clamped_period got %0d want 526", period); end
    endtask

    task automatic test_enable_drop;
        bit ok;
        int bad;
        int w;
        set_all(8'd0);
        capture(0, 0, ok);
        capture(2, 6, ok);
        n_cmp++; if (!ok || n_rise != 9) begin n_fail++; $display("FAIL drop_rise_count got %0d want 9", n_rise); end
        n_cmp++; if (got_next || period != 400) begin n_fail++; $display("FAIL drop_frame_end got %0d next=%0d want 400 next=0", period, got_next); end
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ppm_out !== 1'b0 || frame_start !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL drop_stays_idle got %0d active cycles want 0", bad); end
        enable = 1'b1;
        w = 0;
        while (frame_start !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_cmp++; if (frame_start !== 1'b1 || w > CPT + 1) begin n_fail++; $display("FAIL drop_restart_latency got %0d want <=%0d", w, CPT + 1); end
        start_pending = (frame_start === 1'b1);
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int w;
        capture(0, 0, ok);
        w = 0;
        while (!(slot_index === 3'd4 && ppm_out === 1'b0 && busy === 1'b1) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        n_cmp++; if (slot_index !== 3'd4 || ppm_out !== 1'b0) begin n_fail++; $display("FAIL rst_reach_gap4 slot %0d want 4", slot_index); end
        set_all(8'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (ppm_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ppm_out got %b want 0", ppm_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_cmp++; if (slot_index !== 3'd0) begin n_fail++; $display("FAIL rst_mid_slot got %0d want 0", slot_index); end
        start_pending = 0;
        capture(0, 0, ok);
        n_cmp++; if (!ok || rise_slot[0] != 0) begin n_fail++; $display("FAIL rst_new_frame_slot got %0d want 0", rise_slot[0]); end
        n_cmp++; if (rise_t[1] - rise_t[0] != 24) begin n_fail++; $display("FAIL rst_fresh_spacing got %0d want 24", rise_t[1] - rise_t[0]); end
        n_cmp++; if (!got_next || period != 400) begin n_fail++; $display("FAIL rst_period got %0d want 400", period); end
    endtask

    task automatic test_sync_clamp;
        bit ok;
        set_all(8'd255);
        capture(0, 0, ok);
        capture(0, 0, ok);
        n_cmp++; if (!ok || n_rise != 9) begin n_fail++; $display("FAIL clamp_rise_count got %0d want 9", n_rise); end
        n_cmp++; if (rise_t[8] - rise_t[7] != 530) begin n_fail++; $display("FAIL clamp_spacing got %0d want 530", rise_t[8] - rise_t[7]); end
        // TERM ends at 8*265+3 = 2123 ticks, then the 20-tick minimum sync.
        n_cmp++; if (fall_t[8] != 4246) begin n_fail++; $display("FAIL clamp_term_end got %0d want 4246", fall_t[8]); end
        n_cmp++; if (!got_next || period != 4286) begin n_fail++; $display("FAIL clamp_period got %0d want 4286", period); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        start_pending = 0;
        set_all(8'd0);
        @(negedge clk);
        test_reset;
        test_zero_frame;
        test_mixed_values;
        test_snapshot;
        test_enable_drop;
        test_reset_mid_frame;
        test_sync_clamp;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
